// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register addresses for the renamer.
// Speculative allocations are rolled back on flush; retire returns old mappings.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int W = $clog2(NUM_PHYS_REGS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         alloc_req,
    output logic [W-1:0] alloc_addr,
    output logic         alloc_available,
    input  logic         commit_alloc,
    input  logic         release_valid,
    input  logic [W-1:0] release_addr,
    output logic [W:0]   free_count,
    output logic         init_done
);

    typedef enum logic {INIT, READY} state_e;

    localparam logic [W-1:0] LAST_INIT = W'(NUM_PHYS_REGS - NUM_ARCH_REGS - 1);
    localparam logic [W-1:0] ARCH_BASE = W'(NUM_ARCH_REGS);
    localparam logic [W-1:0] CNT_ONE   = W'(1);
    localparam logic [W:0]   PTR_ONE   = (W+1)'(1);
    localparam logic [W:0]   FREE_REGS = (W+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);

    state_e       state_q, state_d;
    logic [W-1:0] init_cnt_q, init_cnt_d;
    logic [W:0]   wr_ptr_q, wr_ptr_d;
    logic [W:0]   spec_rd_ptr_q, spec_rd_ptr_d;
    logic [W:0]   commit_rd_ptr_q, commit_rd_ptr_d;
    logic         init_done_q, init_done_d;

    logic [W-1:0] mem_q [NUM_PHYS_REGS];
    logic         mem_we;
    logic [W-1:0] mem_wdata;
    logic         do_alloc;
    logic         do_release;

    assign alloc_available = (state_q == READY) && (wr_ptr_q != spec_rd_ptr_q);
    assign alloc_addr      = mem_q[spec_rd_ptr_q[W-1:0]];
    assign free_count      = wr_ptr_q - spec_rd_ptr_q;
    assign init_done       = init_done_q;
    assign do_alloc        = alloc_req & alloc_available & ~flush;
    assign do_release      = release_valid & (release_addr != '0);

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        wr_ptr_d        = wr_ptr_q;
        spec_rd_ptr_d   = spec_rd_ptr_q;
        commit_rd_ptr_d = commit_rd_ptr_q;
        mem_we          = 1'b0;
        mem_wdata       = release_addr;
        unique case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                mem_wdata  = ARCH_BASE + init_cnt_q;
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                init_cnt_d = init_cnt_q + CNT_ONE;
                if (init_cnt_q == LAST_INIT) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (commit_alloc) begin
                    commit_rd_ptr_d = commit_rd_ptr_q + PTR_ONE;
                end
                // flush rewinds to the commit point, including a same-cycle commit
                if (flush) begin
                    spec_rd_ptr_d = commit_rd_ptr_d;
                end else if (do_alloc) begin
                    spec_rd_ptr_d = spec_rd_ptr_q + PTR_ONE;
                end
                if (do_release) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end
            default: ;
        endcase
        init_done_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= INIT;
            init_cnt_q      <= '0;
            wr_ptr_q        <= '0;
            spec_rd_ptr_q   <= '0;
            commit_rd_ptr_q <= '0;
            init_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            spec_rd_ptr_q   <= spec_rd_ptr_d;
            commit_rd_ptr_q <= commit_rd_ptr_d;
            init_done_q     <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[wr_ptr_q[W-1:0]] <= mem_wdata;
        end
    end

    a_alloc_legal: assert property (@(posedge clk) disable iff (rst)
        (state_q == READY && alloc_req && !flush) |-> alloc_available);

    a_commit_legal: assert property (@(posedge clk) disable iff (rst)
        (state_q == READY && commit_alloc)
        |-> (spec_rd_ptr_q != commit_rd_ptr_q) || do_alloc);

    a_no_double_free: assert property (@(posedge clk) disable iff (rst)
        (state_q == READY) |-> ((wr_ptr_q - commit_rd_ptr_q) <= FREE_REGS));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Random and directed bench for phys_reg_free_list against a queue model.
module tb_phys_reg_free_list;

    localparam int NP = 64;
    localparam int NA = 32;
    localparam int W  = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         alloc_req = 1'b0;
    logic [W-1:0] alloc_addr;
    logic         alloc_available;
    logic         commit_alloc = 1'b0;
    logic         release_valid = 1'b0;
    logic [W-1:0] release_addr = '0;
    logic [W:0]   free_count;
    logic         init_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: free_q holds every entry past the commit point, in hand-out order
    int free_q[$];
    int in_use[$];
    int spec_n = 0;
    int init_n = 0;
    bit m_ready = 1'b0;
    int ncom = 0;
    int nrel = 0;

    phys_reg_free_list #(
        .NUM_PHYS_REGS(NP),
        .NUM_ARCH_REGS(NA)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alloc_req      (alloc_req),
        .alloc_addr     (alloc_addr),
        .alloc_available(alloc_available),
        .commit_alloc   (commit_alloc),
        .release_valid  (release_valid),
        .release_addr   (release_addr),
        .free_count     (free_count),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", n, act, exp, $time);
        end
    endfunction

    function automatic bit m_avail();
        return m_ready && (spec_n < free_q.size());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            free_q.delete();
            in_use.delete();
            for (int i = 1; i < NA; i++) in_use.push_back(i);
            spec_n = 0;
            init_n = 0;
            m_ready = 1'b0;
            ncom = 0;
            nrel = 0;
        end else if (!m_ready) begin
            free_q.push_back(NA + init_n);
            init_n++;
            if (init_n == NP - NA) m_ready = 1'b1;
        end else begin
            if (alloc_req && !flush && m_avail()) spec_n++;
            if (commit_alloc) begin
                in_use.push_back(free_q[0]);
                void'(free_q.pop_front());
                spec_n--;
                ncom++;
            end
            if (flush) spec_n = 0;
            if (release_valid && release_addr != 0) begin
                free_q.push_back(int'(release_addr));
                nrel++;
                for (int i = 0; i < in_use.size(); i++) begin
                    if (in_use[i] == int'(release_addr)) begin
                        in_use.delete(i);
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("init_done", init_done, m_ready);
            chk("alloc_available", alloc_available, m_avail());
            chk("free_count", free_count, free_q.size() - spec_n);
            if (m_avail()) chk("alloc_addr", alloc_addr, free_q[spec_n]);
        end
    end

    task automatic drive(input bit a, input bit c, input bit f,
                         input bit rv, input int ra);
        alloc_req     = a;
        commit_alloc  = c;
        flush         = f;
        release_valid = rv;
        release_addr  = W'(ra);
    endtask

    task automatic rand_cycle();
        bit a, c, f, rv;
        int ra;
        f  = ($urandom % 20) == 0;
        a  = m_avail() && ($urandom % 4) != 0;
        c  = (f ? (spec_n > 0) : (spec_n > 0 || a)) && ($urandom % 3) != 0;
        rv = 1'b0;
        ra = 0;
        if (($urandom % 16) == 0) begin
            rv = 1'b1;
        end else if (nrel < ncom && in_use.size() > 0 && ($urandom % 3) != 0) begin
            rv = 1'b1;
            ra = in_use[$urandom_range(0, in_use.size() - 1)];
        end
        drive(a, c, f, rv, ra);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 31) begin
                chk("lit_init_avail", alloc_available, 0);
                chk("lit_init_done", init_done, 0);
            end
        end
        chk("lit_ready_avail", alloc_available, 1);
        chk("lit_first_addr", alloc_addr, 32);
        chk("lit_first_count", free_count, 32);

        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_a33", alloc_addr, 33);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_a34", alloc_addr, 34);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("lit_flush_addr", alloc_addr, 33);
        chk("lit_flush_count", free_count, 31);
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("lit_realloc", alloc_addr, 34);
        for (int j = 34; j < 64; j++) begin
            chk("lit_drain_addr", alloc_addr, j);
            drive(1, 1, 0, 0, 0);
            @(negedge clk);
        end
        chk("lit_empty_avail", alloc_available, 0);
        chk("lit_empty_count", free_count, 0);
        drive(0, 0, 0, 1, 7);
        @(negedge clk);
        chk("lit_rel_avail", alloc_available, 1);
        chk("lit_rel_addr", alloc_addr, 7);
        chk("lit_rel_count", free_count, 1);
        drive(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("lit_rel0_count", free_count, 1);

        for (int n = 0; n < 3000; n++) begin
            rand_cycle();
            @(negedge clk);
        end

        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 31) chk("lit_reinit_avail", alloc_available, 0);
        end
        chk("lit_reinit_addr", alloc_addr, 32);
        chk("lit_reinit_count", free_count, 32);

        for (int n = 0; n < 500; n++) begin
            rand_cycle();
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
